u8mac_seq: RTL and testbench
============================

U8MAC_SEQ -- requirements
Module: u8mac_seq

Interface
REQ-001 SHALL have parameter DEPTH_W, default 16, giving the width of the dot-product length.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the output-pixel count.
REQ-003 SHALL have parameter ADDR_W, default 20, giving the width of the buffer address.
REQ-004 SHALL have port clk  input  1  as the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  as a one-cycle job request.
REQ-007 SHALL have port depth  input  DEPTH_W  as the MAC count per output, captured at start.
REQ-008 SHALL have port n_out  input  CNT_W  as the output count per job, captured at start.
REQ-009 SHALL have port in_stride  input  ADDR_W  as the input address step per output, captured at start.
REQ-010 SHALL have port rdy  input  1  as memory data ready, the same signal that feeds u8mac.rdy.
REQ-011 SHALL have port acvalid  input  1  as the result-valid strobe from u8mac.
REQ-012 SHALL have ports acl, aen, ivalid  output  1 each  as the u8mac clear, accumulate-enable and input-valid controls.
REQ-013 SHALL have ports in_addr, fil_addr  output  ADDR_W each  as the read addresses.
REQ-014 SHALL have ports busy, done  output  1 each  as job active and a one-cycle completion pulse.
REQ-015 SHALL have port out_cnt  output  CNT_W  as the count of acvalid strobes in the current job.

Function
REQ-016 SHALL implement the FSM states IDLE, CLR, ACC, BIAS, DRAIN and DONE.
REQ-017 SHALL advance state and counters in every state except IDLE and DONE only on cycles with rdy=1; with rdy=0, all state and outputs hold.
REQ-018 In IDLE, start with depth!=0 and n_out!=0 SHALL capture the parameters, zero out_idx, k and out_cnt, and go to CLR on the next cycle.
REQ-019 In IDLE, start with depth=0 or n_out=0 SHALL go to DONE with no MAC activity.
REQ-020 CLR SHALL drive acl=1, aen=0 and ivalid=0 for one rdy cycle, then go to ACC with k=0.
REQ-021 ACC SHALL drive aen=1 and ivalid=1, with fil_addr=k and in_addr=out_idx*in_stride+k modulo 2^ADDR_W.
REQ-022 ACC SHALL increment k on each rdy cycle and go to BIAS on the rdy cycle where k==depth-1.
REQ-023 BIAS SHALL drive aen=0 for one rdy cycle, the cycle in which u8mac adds the bias, then go to DRAIN.
REQ-024 DRAIN SHALL hold aen=0 and acl=0 for 3 rdy cycles.
REQ-025 At the end of DRAIN, if out_idx==n_out-1, the FSM SHALL go to DONE; otherwise it SHALL increment out_idx and go to CLR.
REQ-026 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-029 out_cnt SHALL increment on every acvalid=1 while busy=1, be cleared on an accepted start, and hold after DONE until the next start.
REQ-030 With rdy held at 1, each output SHALL take depth+5 cycles, and done SHALL assert n_out*(depth+5)+1 cycles after the start cycle.
REQ-031 acl, aen, ivalid and done SHALL be registered outputs.
REQ-032 The addresses SHALL be 0 outside ACC.

Reset
REQ-033 reset=1 SHALL force IDLE on the next edge in any state, including mid-job, and SHALL override start.
REQ-034 Reset SHALL clear acl, aen, ivalid, busy, done, in_addr, fil_addr and out_cnt to 0.
REQ-035 After a mid-job reset, the block SHALL produce no done pulse for the aborted job.

Configuration
REQ-036 With macro U8MAC_SEQ_PERF_EN defined, the block SHALL add output stall_cnt (32 bits), counting cycles with busy=1 and rdy=0.
REQ-037 stall_cnt SHALL clear on an accepted start or on reset, saturate at all-ones, and hold after DONE.
REQ-038 Without U8MAC_SEQ_PERF_EN, the stall_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 depth=4, n_out=2, in_stride=16, rdy=1 -> done at cycle 19 after start; fil_addr runs 0..3 for each output; in_addr runs 0..3 then 16..19; acl high at cycles 1 and 10.
REQ-040 Same job with rdy low for cycles 3-5 -> all outputs frozen during the stall, done at cycle 22, and stall_cnt=3 when U8MAC_SEQ_PERF_EN is defined.
REQ-041 start with depth=0, n_out=5 -> busy stays 0, done at cycle 1, and acl/aen never assert.
REQ-042 reset asserted during ACC of job depth=8, n_out=3 -> IDLE and all outputs 0 on the next edge, no done; a new start then runs normally.
REQ-043 Second start during a busy job -> ignored; the first job's done timing is unchanged.
REQ-044 in_stride=0xFFFFF, n_out=2, depth=2 -> the second output's in_addr is 0xFFFFF then 0x00000 (wrap), and out_cnt=2 after u8mac returns 2 acvalid strobes.

Source files
------------

// File: rtl/u8mac_seq.sv
// u8mac_seq: job sequencer driving u8mac clear/accumulate/valid controls and read addresses.
// Optional U8MAC_SEQ_PERF_EN adds a saturating stall_cnt output.
module u8mac_seq #(
    parameter int DEPTH_W = 16,
    parameter int CNT_W   = 16,
    parameter int ADDR_W  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DEPTH_W-1:0] depth,
    input  logic [CNT_W-1:0]   n_out,
    input  logic [ADDR_W-1:0]  in_stride,
    input  logic               rdy,
    input  logic               acvalid,
    output logic               acl,
    output logic               aen,
    output logic               ivalid,
    output logic [ADDR_W-1:0]  in_addr,
    output logic [ADDR_W-1:0]  fil_addr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   out_cnt
`ifdef U8MAC_SEQ_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, CLR, ACC, BIAS, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [DEPTH_W-1:0] depth_q, k, k_n;
    logic [CNT_W-1:0]   n_q, idx, idx_n;
    logic [ADDR_W-1:0]  stride_q, base, base_n;
    logic               nop, go;
    assign go   = state == IDLE && start;
    // an empty job passes through DONE without ever looking busy
    assign busy = state != IDLE && !nop;
    always_comb begin
        state_n = state;
        k_n     = k;
        idx_n   = idx;
        base_n  = base;
        case (state)
            IDLE: if (start) begin
                state_n = (depth == '0 || n_out == '0) ? DONE : CLR;
                k_n     = '0;
                idx_n   = '0;
                base_n  = '0;
            end
            CLR: if (rdy) begin
                state_n = ACC;
                k_n     = '0;
            end
            ACC: if (rdy) begin
                k_n     = (k == depth_q - 1'b1) ? '0 : k + 1'b1;
                state_n = (k == depth_q - 1'b1) ? BIAS : ACC;
            end
            BIAS: if (rdy) begin
                state_n = DRAIN;
                k_n     = '0;
            end
            DRAIN: if (rdy) begin
                // k doubles as the drain cycle counter
                k_n = (k == DEPTH_W'(2)) ? '0 : k + 1'b1;
                if (k == DEPTH_W'(2)) begin
                    state_n = (idx == n_q - 1'b1) ? DONE : CLR;
                    idx_n   = (idx == n_q - 1'b1) ? idx : idx + 1'b1;
                    base_n  = (idx == n_q - 1'b1) ? base : base + stride_q;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k        <= '0;
            idx      <= '0;
            base     <= '0;
            depth_q  <= '0;
            n_q      <= '0;
            stride_q <= '0;
            nop      <= 1'b0;
            acl      <= 1'b0;
            aen      <= 1'b0;
            ivalid   <= 1'b0;
            done     <= 1'b0;
            in_addr  <= '0;
            fil_addr <= '0;
            out_cnt  <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            idx      <= idx_n;
            base     <= base_n;
            acl      <= state_n == CLR;
            aen      <= state_n == ACC;
            ivalid   <= state_n == ACC;
            done     <= state_n == DONE;
            fil_addr <= (state_n == ACC) ? ADDR_W'(k_n) : '0;
            in_addr  <= (state_n == ACC) ? base_n + ADDR_W'(k_n) : '0;
            out_cnt  <= go ? '0 : out_cnt + CNT_W'(acvalid && busy);
            if (go) begin
                depth_q  <= depth;
                n_q      <= n_out;
                stride_q <= in_stride;
                nop      <= depth == '0 || n_out == '0;
            end
        end
    end
`ifdef U8MAC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || go) stall_cnt <= '0;
        else stall_cnt <= stall_cnt + 32'(busy && !rdy && stall_cnt != '1);
    end
`endif
endmodule

// File: tb/tb_u8mac_seq.sv
// tb_u8mac_seq: per-rdy-cycle expected-output schedule model, cycle-by-cycle compare, directed literal checks.
module tb_u8mac_seq;
    logic        clk = 0, reset = 1, start = 0, rdy = 1, acvalid = 0;
    logic [15:0] depth = 0, n_out = 0;
    logic [19:0] in_stride = 0;
    logic        acl, aen, ivalid, busy, done;
    logic [19:0] in_addr, fil_addr;
    logic [15:0] out_cnt;
`ifdef U8MAC_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif
    int tests = 0, fails = 0, cyc = 0, s0 = 0, lat;
    bit chk_en = 0, any_act = 0, any_done;

    typedef struct packed {
        logic b, a, e, iv, d;
        logic [19:0] ia, fa;
    } exp_t;
    exp_t q[$];
    logic [15:0] m_cnt = 0;
    logic [31:0] m_stall = 0;
    int mon_acl[$];
    logic [19:0] mon_ia[$], mon_fa[$];

    u8mac_seq dut (
        .clk(clk), .reset(reset), .start(start), .depth(depth), .n_out(n_out),
        .in_stride(in_stride), .rdy(rdy), .acvalid(acvalid), .acl(acl), .aen(aen),
        .ivalid(ivalid), .in_addr(in_addr), .fil_addr(fil_addr), .busy(busy),
        .done(done), .out_cnt(out_cnt)
`ifdef U8MAC_SEQ_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic push(input bit b, a, e, d, input logic [19:0] ia, fa);
        exp_t x;
        x = '{b: b, a: a, e: e, iv: e, d: d, ia: ia, fa: fa};
        q.push_back(x);
    endtask

    // one schedule entry per rdy cycle the job occupies
    task automatic build(input logic [15:0] d, n, input logic [19:0] st);
        if (d == 0 || n == 0) push(0, 0, 0, 1, 0, 0);
        else begin
            for (int o = 0; o < int'(n); o++) begin
                push(1, 1, 0, 0, 0, 0);
                for (int k = 0; k < int'(d); k++)
                    push(1, 0, 1, 0, 20'(longint'(o) * longint'(st) + longint'(k)), 20'(k));
                repeat (4) push(1, 0, 0, 0, 0, 0);
            end
            push(1, 0, 0, 1, 0, 0);
        end
    endtask

    always @(posedge clk) begin : model
        exp_t cur;
        bit act;
        act = q.size() > 0;
        cur = act ? q[0] : '0;
        if (reset) begin
            q.delete();
            m_cnt = 0;
            m_stall = 0;
        end else begin
            if (cur.b && acvalid) m_cnt++;
            if (cur.b && !rdy && m_stall != '1) m_stall++;
            if (act) begin
                if (cur.d || rdy) void'(q.pop_front());
            end else if (start) begin
                m_cnt = 0;
                m_stall = 0;
                build(depth, n_out, in_stride);
            end
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        if (chk_en) begin
            e = (q.size() > 0) ? q[0] : '0;
            tests++;
            if ({busy, acl, aen, ivalid, done, in_addr, fil_addr} !== e) begin
                fails++;
                $display("FAIL outputs cyc %0d: got busy=%b acl=%b aen=%b ivalid=%b done=%b in_addr=%h fil_addr=%h, want %b %b %b %b %b %h %h",
                         cyc, busy, acl, aen, ivalid, done, in_addr, fil_addr, e.b, e.a, e.e, e.iv, e.d, e.ia, e.fa);
            end
            tests++;
            if (out_cnt !== m_cnt) begin
                fails++;
                $display("FAIL out_cnt cyc %0d: got %0d want %0d", cyc, out_cnt, m_cnt);
            end
`ifdef U8MAC_SEQ_PERF_EN
            tests++;
            if (stall_cnt !== m_stall) begin
                fails++;
                $display("FAIL stall_cnt cyc %0d: got %0d want %0d", cyc, stall_cnt, m_stall);
            end
`endif
            if (acl) mon_acl.push_back(cyc - s0);
            if (aen) begin
                mon_ia.push_back(in_addr);
                mon_fa.push_back(fil_addr);
            end
            if (acl || aen || busy) any_act = 1;
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [15:0] d, n, input logic [19:0] st,
                           input int st_lo, st_hi, acv_n, rs, output int l);
        mon_acl.delete();
        mon_ia.delete();
        mon_fa.delete();
        any_act = 0;
        depth = d;
        n_out = n;
        in_stride = st;
        start = 1;
        rdy = 1;
        s0 = cyc;
        l = -1;
        tick();
        start = 0;
        for (int c = 1; c < 400 && l < 0; c++) begin
            rdy = !(c >= st_lo && c <= st_hi);
            acvalid = (c >= 2 && c < 2 + acv_n);
            start = (c == rs);
            if (c == rs) depth = 16'd1;
            @(negedge clk);
            if (done) l = c;
            tick();
        end
        start = 0;
        rdy = 1;
        acvalid = 0;
    endtask

    initial begin
        reset = 1;
        tick();
        chk_en = 1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_ctrl", {acl, aen, ivalid, done}, 0);
        chk("reset_addr", {in_addr, fil_addr}, 0);
        chk("reset_out_cnt", out_cnt, 0);
        tick();
        reset = 0;
        tick();

        run_job(4, 2, 16, 0, -1, 0, 0, lat);
        chk("basic_done_cycle", lat, 19);
        chk("basic_acl_count", mon_acl.size(), 2);
        if (mon_acl.size() == 2) begin
            chk("basic_acl_cyc0", mon_acl[0], 1);
            chk("basic_acl_cyc1", mon_acl[1], 10);
        end
        chk("basic_addr_count", mon_ia.size(), 8);
        if (mon_ia.size() == 8)
            for (int i = 0; i < 8; i++) begin
                chk("basic_in_addr", mon_ia[i], (i < 4) ? i : 12 + i);
                chk("basic_fil_addr", mon_fa[i], i % 4);
            end

        run_job(4, 2, 16, 3, 5, 0, 0, lat);
        chk("stall_done_cycle", lat, 22);
`ifdef U8MAC_SEQ_PERF_EN
        chk("stall_cnt_value", stall_cnt, 3);
`endif

        run_job(0, 5, 16, 0, -1, 0, 0, lat);
        chk("empty_done_cycle", lat, 1);
        chk("empty_no_activity", any_act, 0);

        run_job(4, 2, 16, 0, -1, 0, 5, lat);
        chk("restart_mid_ignored", lat, 19);
        run_job(4, 2, 16, 0, -1, 0, 19, lat);
        chk("restart_at_done_ignored", lat, 19);
        chk("restart_at_done_idle", busy, 0);

        run_job(2, 2, 20'hFFFFF, 0, -1, 2, 0, lat);
        chk("wrap_done_cycle", lat, 15);
        chk("wrap_addr_count", mon_ia.size(), 4);
        if (mon_ia.size() == 4) begin
            chk("wrap_in_addr2", mon_ia[2], 20'hFFFFF);
            chk("wrap_in_addr3", mon_ia[3], 0);
        end
        chk("wrap_out_cnt", out_cnt, 2);

        depth = 8;
        n_out = 3;
        in_stride = 7;
        start = 1;
        tick();
        start = 0;
        repeat (4) tick();
        reset = 1;
        start = 1;
        tick();
        reset = 0;
        start = 0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ctrl", {acl, aen, ivalid, done}, 0);
        chk("abort_addr", {in_addr, fil_addr}, 0);
        any_done = 0;
        repeat (20) begin
            tick();
            @(negedge clk);
            if (done) any_done = 1;
        end
        chk("abort_no_done", any_done, 0);
        tick();
        run_job(3, 2, 5, 0, -1, 0, 0, lat);
        chk("after_abort_done_cycle", lat, 17);

        repeat (3000) begin
            rdy = ($urandom % 4) != 0;
            acvalid = rdy && ($urandom % 3 == 0);
            start = ($urandom % 6) == 0;
            depth = 16'($urandom % 7);
            n_out = 16'($urandom % 4);
            in_stride = 20'($urandom);
            reset = ($urandom % 250) == 0;
            tick();
        end
        reset = 0;
        start = 0;
        rdy = 1;
        acvalid = 0;
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
